// File: rtl/bg_seq_pkg.sv
// Shared types and constants for the background layer sequencer.
package bg_seq_pkg;

    // Sequencer states; the encoding is visible in STATUS[4:3].
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    // Register map.
    localparam logic [1:0] ADDR_MODE   = 2'd0;
    localparam logic [1:0] ADDR_DWELL  = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // STATUS bit that clears the sticky interrupt when written with 1.
    localparam int STATUS_IRQ_BIT = 7;

    // MODE register, laid out to match write-data bits [4:0].
    typedef struct packed {
        logic       irq_en;  // [4]
        logic [1:0] msel;    // [3:2]
        logic       auto_en; // [1]
        logic       run;     // [0]
    } mode_t;

endpackage

// File: rtl/bg_next_sel.sv
// Rotating-priority picker: first set mask bit strictly above cur, wrapping
// around and ending on cur itself, so a lone eligible layer picks itself.
module bg_next_sel #(
    parameter int NUM_BG = 3
) (
    input  logic [NUM_BG-1:0] mask,
    input  logic [1:0]        cur,
    output logic [1:0]        nxt,
    output logic              valid
);

    logic [3:0] mask_ext;
    logic [1:0] idx;

    assign mask_ext = 4'(mask);

    // Scan cur+1, cur+2, ... cur (mod NUM_BG) and keep the first hit.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        nxt   = cur;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_BG; i++) begin
            idx = 2'((int'(cur) + i) % NUM_BG);
            if (!valid && mask_ext[idx]) begin
                nxt   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bg_layer_sequencer.sv
// Chooses which background layer feeds the pixel mux. Layer changes happen
// only on a vsync rising edge and are separated by blank frames.
module bg_layer_sequencer
    import bg_seq_pkg::*;
#(
    parameter int NUM_BG       = 3,
    parameter int DWELL_W      = 8,
    parameter int BLANK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic [7:0]        cfg_rdata,
    input  logic              vsync,
    output logic              vga_en,
    output logic [NUM_BG-1:0] layer_en,
    output logic              irq
);

    localparam int BLK_W = (BLANK_FRAMES < 2) ? 1 : $clog2(BLANK_FRAMES);

    mode_t               mode_q, mode_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [NUM_BG-1:0]   mask_q, mask_d;
    state_e              state_q, state_d;
    logic [1:0]          cur_q, cur_d;
    logic [1:0]          nxt_q, nxt_d;
    logic [DWELL_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [BLK_W-1:0]    blank_cnt_q, blank_cnt_d;
    logic                vsync_q;
    logic                vga_en_q, vga_en_d;
    logic [NUM_BG-1:0]   layer_en_q, layer_en_d;
    logic                irq_q, irq_d;

    logic                frame_tick;
    logic [3:0]          mask_ext;
    logic                msel_ok;
    logic                irq_set;
    logic                irq_clr;
    logic [DWELL_W-1:0]  dwell_last;
    logic [1:0]          pick_from;
    logic [1:0]          pick_nxt;
    logic                pick_valid;
    logic [1:0]          unused_wdata;

    assign unused_wdata = cfg_wdata[6:5];
    assign frame_tick   = vsync & ~vsync_q;
    assign mask_ext     = 4'(mask_q);
    // msel is only honoured when it names an existing, eligible layer.
    assign msel_ok      = mask_ext[mode_q.msel];
    // A DWELL of 0 behaves like 1.
    assign dwell_last   = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    // From IDLE, starting the scan at the top layer yields the lowest set bit.
    assign pick_from    = (state_q == ST_IDLE) ? 2'(NUM_BG - 1) : cur_q;
    assign irq_clr      = cfg_we && (cfg_addr == ADDR_STATUS) && cfg_wdata[STATUS_IRQ_BIT];

    bg_next_sel #(.NUM_BG(NUM_BG)) u_next_sel (
        .mask  (mask_q),
        .cur   (pick_from),
        .nxt   (pick_nxt),
        .valid (pick_valid)
    );

    // Register file writes; the FSM below still sees the old values this cycle.
    always_comb begin
        mode_d  = mode_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        if (cfg_we) begin
            case (cfg_addr)
                ADDR_MODE:  mode_d  = mode_t'(cfg_wdata[4:0]);
                ADDR_DWELL: dwell_d = cfg_wdata[DWELL_W-1:0];
                ADDR_MASK:  mask_d  = cfg_wdata[NUM_BG-1:0];
                default:    ;
            endcase
        end
    end

    // Layer scheduling: run/mask loss aborts at once, everything else waits for a frame tick.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        frame_cnt_d = frame_cnt_q;
        blank_cnt_d = blank_cnt_q;
        irq_set     = 1'b0;
        if (!mode_q.run || (state_q != ST_IDLE && mask_q == '0)) begin
            state_d     = ST_IDLE;
            frame_cnt_d = '0;
            blank_cnt_d = '0;
        end else if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (mask_q != '0) begin
                        if (mode_q.auto_en && pick_valid) begin
                            cur_d       = pick_nxt;
                            state_d     = ST_SHOW;
                            frame_cnt_d = '0;
                        end else if (!mode_q.auto_en && msel_ok) begin
                            cur_d       = mode_q.msel;
                            state_d     = ST_SHOW;
                            frame_cnt_d = '0;
                        end
                    end
                end
                ST_SHOW: begin
                    if (mode_q.auto_en) begin
                        // Losing the current layer from MASK counts as dwell expiry.
                        if (frame_cnt_q >= dwell_last || !mask_ext[cur_q]) begin
                            frame_cnt_d = '0;
                            if (pick_valid && pick_nxt != cur_q) begin
                                nxt_d       = pick_nxt;
                                blank_cnt_d = '0;
                                state_d     = ST_BLANK;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 1'b1;
                        end
                    end else if (msel_ok && mode_q.msel != cur_q) begin
                        nxt_d       = mode_q.msel;
                        blank_cnt_d = '0;
                        state_d     = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (blank_cnt_q == BLK_W'(BLANK_FRAMES - 1)) begin
                        cur_d       = nxt_q;
                        blank_cnt_d = '0;
                        frame_cnt_d = '0;
                        state_d     = ST_SHOW;
                        irq_set     = mode_q.irq_en;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs, derived from next-state so they move with the FSM; irq set beats clear.
    always_comb begin
        vga_en_d   = mode_d.run;
        layer_en_d = (state_d == ST_SHOW) ? (NUM_BG'(1) << cur_d) : '0;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // All state in one place with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= only so every flop samples pre-edge values.
        if (reset) begin
            mode_q      <= '0;
            dwell_q     <= '0;
            mask_q      <= '0;
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            nxt_q       <= '0;
            frame_cnt_q <= '0;
            blank_cnt_q <= '0;
            vsync_q     <= 1'b0;
            vga_en_q    <= 1'b0;
            layer_en_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            dwell_q     <= dwell_d;
            mask_q      <= mask_d;
            state_q     <= state_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            frame_cnt_q <= frame_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            vsync_q     <= vsync;
            vga_en_q    <= vga_en_d;
            layer_en_q  <= layer_en_d;
            irq_q       <= irq_d;
        end
    end

    // Register read-back, combinational from the address.
    always_comb begin
        case (cfg_addr)
            ADDR_MODE:  cfg_rdata = {3'b000, mode_q};
            ADDR_DWELL: cfg_rdata = 8'(dwell_q);
            ADDR_MASK:  cfg_rdata = 8'(mask_q);
            default:    cfg_rdata = {irq_q, 2'b00, state_q, cur_q, 1'b0};
        endcase
    end

    assign vga_en   = vga_en_q;
    assign layer_en = layer_en_q;
    assign irq      = irq_q;

endmodule
